// File: rtl/key_encoder_pkg.sv
// key_encoder_pkg: message fields, note constants and FSM encoding shared by the note path
package key_encoder_pkg;
    localparam int NOTE_ON_BIT = 7;
    localparam int ID_MSB = 6;
    localparam int NOTES_PER_OCTAVE = 13;
    localparam logic [6:0] NOTE_REST = 7'd0;
    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
    function automatic logic [1:0] octave_of(input logic [1:0] pitch_db);
        return (pitch_db == 2'b10) ? 2'd0 : (pitch_db == 2'b01) ? 2'd2 : 2'd1;
    endfunction
endpackage

// File: rtl/key_encoder_if.sv
// key_encoder_if: key/pitch inputs and note message outputs of the manual-play front end
interface key_encoder_if;
    logic [12:0] key;
    logic [1:0]  pitch;
    logic        msg_stb;
    logic [7:0]  msg;
    logic        active;
    modport master (output key, pitch, input msg_stb, msg, active);
    modport slave (input key, pitch, output msg_stb, msg, active);
endinterface

// File: rtl/key_encoder_debounce_bit.sv
// debounce_bit: 2-FF synchroniser plus tick-driven debounce counter for one active-low input
module debounce_bit #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic dout
);
    logic [1:0] sync_q, sync_d;
    logic [3:0] cnt_q, cnt_d, inc;
    logic       db_q, db_d, hit;
    always_comb begin
        sync_d = {sync_q[0], din};
        inc = cnt_q + 4'd1;
        hit = tick && (sync_q[1] != db_q) && (inc == 4'(DEBOUNCE_MS));
        cnt_d = !tick ? cnt_q : ((sync_q[1] == db_q) || hit) ? 4'd0 : inc;
        db_d = hit ? sync_q[1] : db_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= 4'd0;
            db_q   <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end
    assign dout = db_q;
endmodule

// File: rtl/key_encoder.sv
// key_encoder: debounced piano keys/pitch buttons to note-on/off strobes; KEY_ENCODER_OCTAVE_LATCH_EN latches the octave while a note sounds
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int CLK_FREQ    = 120_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int GAP_CYCLES  = 16
) (
    input logic           clk,
    input logic           rst,
    key_encoder_if.slave  bus
);
    localparam int DIV = CLK_FREQ / 1000;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW  = $clog2(GAP_CYCLES);
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [14:0]   raw, db;
    logic [12:0]   key_db;
    logic [1:0]    pitch_db, oct;
    logic [3:0]    k_idx;
    logic          any_key;
    logic [6:0]    cand;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [6:0]    note_q, note_d;
    logic [7:0]    msg_q, msg_d;
    logic          stb_q, stb_d;
    assign tick  = (div_q == DW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + DW'(1);
    assign raw   = {bus.pitch, bus.key};
    for (genvar i = 0; i < 15; i++) begin : g_db
        debounce_bit #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .din  (raw[i]),
            .dout (db[i])
        );
    end
    assign key_db   = db[12:0];
    assign pitch_db = db[14:13];
    assign any_key  = ~&key_db;
    always_comb begin
        k_idx = 4'd0;
        for (int j = 12; j >= 0; j--)
            if (!key_db[j]) k_idx = 4'(j);
    end
`ifdef KEY_ENCODER_OCTAVE_LATCH_EN
    logic [1:0] oct_q;
    // tracks the live octave only while silent, so it freezes on the 0 -> note edge
    assign oct = (note_q == NOTE_REST) ? octave_of(pitch_db) : oct_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) oct_q <= 2'd1;
        else     oct_q <= oct;
    end
`else
    assign oct = octave_of(pitch_db);
`endif
    assign cand = any_key ? 7'(oct) * 7'(NOTES_PER_OCTAVE) + 7'(k_idx) + 7'd1 : NOTE_REST;
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        note_d  = note_q;
        msg_d   = msg_q;
        stb_d   = 1'b0;
        case (state_q)
            IDLE: state_d = (cand != note_q) ? EMIT : IDLE;
            EMIT: begin
                stb_d               = 1'b1;
                msg_d[NOTE_ON_BIT]  = (cand != NOTE_REST);
                msg_d[ID_MSB:0]     = (cand != NOTE_REST) ? cand : note_q;
                note_d              = cand;
                gap_d               = '0;
                state_d             = GAP;
            end
            GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = (gap_q == GW'(GAP_CYCLES - 2)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= IDLE;
            gap_q   <= '0;
            note_q  <= NOTE_REST;
            msg_q   <= 8'h00;
            stb_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            msg_q   <= msg_d;
            stb_q   <= stb_d;
        end
    end
    assign bus.msg_stb = stb_q;
    assign bus.msg     = msg_q;
    assign bus.active  = (note_q != NOTE_REST);
endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: randomized and directed stimulus against a level-based note model
module tb_key_encoder;
    localparam int GAP    = 16;
    localparam int SETTLE = 220;
    logic clk = 1'b0;
    logic rst = 1'b1;
    key_encoder_if bus ();
    key_encoder #(.CLK_FREQ(10_000), .DEBOUNCE_MS(10), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0, last_stb = -1000;
    int prev_id = 0, lat_oct = 1;
    logic [7:0] last_msg = 8'h00;
    logic [7:0] seen[$];
    task automatic check(string tag, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst) last_stb = -1000;
        else if (bus.msg_stb) begin
            check("spacing", int'(cyc - last_stb >= GAP), 1);
            last_stb = cyc;
            seen.push_back(bus.msg);
        end
    end
    function automatic int octave(logic [1:0] p);
        if (!p[0] && p[1]) return 0;
        if (!p[1] && p[0]) return 2;
        return 1;
    endfunction
    function automatic int lowest(logic [12:0] k);
        for (int i = 0; i < 13; i++) if (!k[i]) return i;
        return -1;
    endfunction
    task automatic step(string tag, logic [12:0] k, logic [1:0] p);
        int oct, idx, id, n_exp;
        logic [7:0] m;
        oct = octave(p);
`ifdef KEY_ENCODER_OCTAVE_LATCH_EN
        if (prev_id != 0) oct = lat_oct;
        else lat_oct = oct;
`endif
        idx = lowest(k);
        id = (idx < 0) ? 0 : oct * 13 + idx + 1;
        n_exp = (id != prev_id) ? 1 : 0;
        m = (id != 0) ? 8'(128 + id) : 8'(prev_id);
        if (n_exp == 1) last_msg = m;
        seen.delete();
        @(negedge clk);
        bus.key = k;
        bus.pitch = p;
        repeat (SETTLE) @(negedge clk);
        check({tag, "_cnt"}, seen.size(), n_exp);
        if (n_exp == 1 && seen.size() == 1) check({tag, "_msg"}, seen[0], m);
        check({tag, "_hold"}, bus.msg, last_msg);
        check({tag, "_act"}, bus.active, (id != 0) ? 1 : 0);
        prev_id = id;
    endtask
    initial begin
        int t, n;
        logic [12:0] k;
        logic [1:0] p;
        bus.key = '1;
        bus.pitch = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_stb", bus.msg_stb, 0);
        check("rst_msg", bus.msg, 0);
        check("rst_act", bus.active, 0);
        rst = 1'b0;
        step("k4_on", 13'h1FEF, 2'b11);
        step("k4_off", 13'h1FFF, 2'b11);
        seen.delete();
        t = 0;
        while (t < 30) begin
            @(negedge clk);
            bus.key[0] = ~bus.key[0];
            n = $urandom_range(1, 6);
            repeat (n) @(negedge clk);
            t += n + 1;
        end
        bus.key = '1;
        repeat (SETTLE) @(negedge clk);
        check("bounce_cnt", seen.size(), 0);
        check("bounce_act", bus.active, 0);
        step("hi_k12", 13'h0FFF, 2'b01);
        step("hi_k2", 13'h0FFB, 2'b01);
        step("hi_rel", 13'h1FFF, 2'b11);
        step("oct1_k0", 13'h1FFE, 2'b11);
        step("oct_shift", 13'h1FFE, 2'b10);
        step("oct_rel", 13'h1FFF, 2'b11);
        step("gap_base", 13'h1FF7, 2'b11);
        seen.delete();
        @(negedge clk);
        bus.key = 13'h1FF5;
        repeat (10) @(negedge clk);
        bus.key[0] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("gap_cnt", seen.size(), 2);
        if (seen.size() == 2) begin
            check("gap_first", seen[0], 8'h8F);
            check("gap_last", seen[1], 8'h8E);
        end
        check("gap_hold", bus.msg, 8'h8E);
        prev_id = 14;
        last_msg = 8'h8E;
        step("gap_rel", 13'h1FFF, 2'b11);
        for (int s = 0; s < 20; s++) begin
            k = '1;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) k[$urandom_range(0, 12)] = 1'b0;
            p = 2'($urandom_range(0, 3));
            step($sformatf("rnd%0d", s), k, p);
        end
        step("pre_rst", 13'h1FFF, 2'b11);
        seen.delete();
        @(negedge clk);
        bus.key = 13'h1FDF;
        for (int i = 0; i < 300 && seen.size() == 0; i++) @(negedge clk);
        check("k5_first_cnt", seen.size(), 1);
        if (seen.size() > 0) check("k5_first_msg", seen[0], 8'h93);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stb", bus.msg_stb, 0);
        check("midrst_msg", bus.msg, 0);
        check("midrst_act", bus.active, 0);
        rst = 1'b0;
        prev_id = 0;
        lat_oct = 1;
        last_msg = 8'h00;
        step("rst_reon", 13'h1FDF, 2'b11);
        step("rst_rel", 13'h1FFF, 2'b11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_encoder.md
# key_encoder

Front-end stage for the manual-play path: samples the 13 active-low piano keys and the 2 active-low pitch buttons, synchronises and debounces them, picks one sounding note, and emits 8-bit note messages. It sits upstream of the player and display stages, alongside autoplay as the other message source. Messages are single-cycle strobes in the system clock domain, and the message format matches autoplay's.

## Interface
- CLK_FREQ, 120_000_000: system clock frequency in Hz.
- DEBOUNCE_MS, 10: debounce time in ms. Allowed range is 1..15.
- GAP_CYCLES, 16: minimum number of clock cycles between two msg_stb pulses. Must be ≥2.
- clk  in  1  system clock (pll output).
- rst  in  1  reset, asynchronous, active-high.
- key  in  13  piano keys, active-low, asynchronous to clk.
- pitch  in  2  pitch[0]=low-octave button, pitch[1]=high-octave button, active-low, asynchronous.
- msg_stb  out  1  one-cycle pulse; msg is valid in that cycle.
- msg  out  8  msg[7]=1 note-on / 0 note-off; msg[6:0]=note id.
- active  out  1  high while a debounced key is held.

## Operation
- **Synchronisation:** each of the 15 inputs goes through a 2-FF synchroniser.
- **Debounce tick:** a shared divider produces a 1 ms tick every CLK_FREQ/1000 cycles.
- **Per-input debounce:** each input has a 4-bit counter.
  - On a tick, if the synchronised sample differs from the debounced value, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_MS, the debounced value takes the sample and the counter clears.
- **Octave selection** (debounced pitch):
  - only pitch[0] low → 0
  - only pitch[1] low → 2
  - neither or both low → 1
- **Note id:** octave*13 + k + 1, where k is the lowest index of the pressed debounced keys. Range is 1..39. Id 0 means no key pressed. Arithmetic is 7-bit unsigned with no overflow.
- **Candidate id:** recomputed every cycle. A note-id register holds the last announced id and resets to 0.
- **FSM states:** IDLE, EMIT, GAP.
  - IDLE: when candidate ≠ note-id register, go to EMIT.
  - EMIT: lasts one cycle.
    - If candidate ≠ 0: msg = {1'b1, candidate}.
    - If candidate = 0: msg = {1'b0, old id}.
    - msg_stb = 1, the note-id register takes candidate, then go to GAP.
  - GAP: counts GAP_CYCLES-1 cycles, then returns to IDLE. Changes during GAP are picked up on return to IDLE; no change is lost, but intermediate values may be skipped.
- **Note changes:** a change from note A to note B emits only note-on B; there is no note-off for A. A change from A to silence emits note-off A.
- **Message register:** msg holds its last value between strobes.
- **active:** equals (note-id register ≠ 0).

## Timing
- **Reset values:** msg_stb=0, msg=8'h00, active=0, FSM in IDLE, all debounced values=1 (released), counters and divider at 0.
- **Latency:** clean key press → msg_stb is 2 (sync) + up to DEBOUNCE_MS+1 ticks + 1 (IDLE→EMIT) + 1 (EMIT) cycles. Worst case at defaults: ≤ 11 ms + 4 cycles.
- **Bounce rejection:** any bounce shorter than DEBOUNCE_MS ms produces no message.
- **Strobe spacing:** msg_stb pulses are always ≥ GAP_CYCLES cycles apart.
- **Simultaneous key and pitch change:** produces a single note-on carrying the combined new id.
- **Reset mid-operation:** asserting rst during EMIT or GAP aborts immediately and emits nothing further. After release, a key still held is re-debounced and re-announced with a note-on.

## Configuration
- **Macro:** KEY_ENCODER_OCTAVE_LATCH_EN.
- **When defined:** the octave is captured when the note-id register goes from 0 to non-0. Pitch-button changes while any key is held are ignored until all keys are released.
- **When undefined (default):** the octave is live. A pitch change while a key is held emits a new note-on with the retuned id.

## Structure
- **Shared package (used by autoplay and player too):**
  - message field positions: NOTE_ON_BIT=7, ID_MSB=6
  - NOTES_PER_OCTAVE=13, NOTE_REST=0
  - FSM state encoding
- **Sub-module:** `debounce_bit`, instantiated 15 times and sharing the 1 ms tick. It contains the synchroniser, the counter and the debounced output.

## Test plan
- Press key[4] cleanly, pitch idle → one strobe with msg=8'h92 (on, id 18). Release → msg=8'h12 (off, id 18).
- Toggle key[0] for 3 ms, then release → no strobe.
- Hold pitch[1] low, press key[12] → msg=8'hA7 (id 39). Then press key[2] as well → msg=8'h9D (id 29).
- Hold key[0] in octave 1 and press pitch[0]:
  - macro undefined → msg=8'h81 (on, id 1);
  - macro defined → no strobe, id stays 14.
- Change keys twice within a GAP_CYCLES=16 window → strobes ≥16 cycles apart, and the final strobe carries the final id.
- Assert rst during GAP while key[5] is held → outputs reset to 0. After release, one note-on msg=8'h93 follows the debounce time.
